// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register and its upstream sequencer:
// select codes, sequencer state encoding and a select helper.
package usr_pkg;

  localparam logic [1:0] SEL_HOLD = 2'd0;
  localparam logic [1:0] SEL_SHR  = 2'd1;
  localparam logic [1:0] SEL_SHL  = 2'd2;
  localparam logic [1:0] SEL_LOAD = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // dir=1 means MSB first, which the USR produces by shifting left.
  function automatic logic [1:0] shift_sel(input logic dir);
    return dir ? SEL_SHL : SEL_SHR;
  endfunction

endpackage

// File: rtl/usr_bit_counter.sv
// Shift-cycle counter for the sequencer: synchronous clear, enable, and a
// terminal flag at WIDTH-1 where it saturates instead of wrapping.
module usr_bit_counter #(
  parameter int WIDTH = 4,
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          enable,
  output logic [CW-1:0] count,
  output logic          terminal
);

  assign terminal = (count == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !terminal) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/usr_shift_sequencer.sv
// Sequencer feeding a universal shift register: one LOAD cycle then WIDTH shift
// cycles per accepted word. Optional tx_stall input under USR_SEQ_STALL_EN.
module usr_shift_sequencer
  import usr_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_dir,
  input  logic             fill_bit,
`ifdef USR_SEQ_STALL_EN
  input  logic             tx_stall,
`endif
  output logic [1:0]       usr_select,
  output logic [WIDTH-1:0] usr_parallel,
  output logic             usr_sright_in,
  output logic             usr_sleft_in,
  input  logic             usr_sright_out,
  input  logic             usr_sleft_out,
  output logic             tx_bit,
  output logic             tx_valid,
  output logic             done,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t          state;
  logic            dir_q;
  logic [1:0]      sel_q;
  logic            tx_valid_q;
  logic            shift_stall;
  logic [CW-1:0]   count;
  logic            count_last;

`ifdef USR_SEQ_STALL_EN
  // Stall must freeze the USR in the same cycle, so it gates the registered select.
  assign shift_stall = tx_stall && (state == ST_SHIFT);
`else
  assign shift_stall = 1'b0;
`endif

  assign usr_select = shift_stall ? SEL_HOLD : sel_q;
  assign tx_valid   = tx_valid_q && !shift_stall;
  assign tx_bit     = dir_q ? usr_sleft_out : usr_sright_out;

  usr_bit_counter #(
    .WIDTH (WIDTH)
  ) u_bit_counter (
    .clk      (clk),
    .rst      (rst),
    .clear    (state == ST_LOAD),
    .enable   ((state == ST_SHIFT) && !shift_stall),
    .count    (count),
    .terminal (count_last)
  );

  // NOTE: every register here uses <= so all state updates see pre-edge values;
  // blocking assignments would make the outputs depend on statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      dir_q         <= 1'b0;
      sel_q         <= SEL_HOLD;
      usr_parallel  <= '0;
      usr_sright_in <= 1'b0;
      usr_sleft_in  <= 1'b0;
      tx_valid_q    <= 1'b0;
      done          <= 1'b0;
      busy          <= 1'b0;
      in_ready      <= 1'b1;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            state        <= ST_LOAD;
            dir_q        <= in_dir;
            sel_q        <= SEL_LOAD;
            usr_parallel <= in_data;
            // Fill enters the vacated end; the opposite serial input stays 0.
            usr_sleft_in  <= in_dir ? 1'b0 : fill_bit;
            usr_sright_in <= in_dir ? fill_bit : 1'b0;
            busy         <= 1'b1;
            in_ready     <= 1'b0;
          end
        end
        ST_LOAD: begin
          state      <= ST_SHIFT;
          sel_q      <= shift_sel(dir_q);
          tx_valid_q <= 1'b1;
        end
        ST_SHIFT: begin
          if (!shift_stall && count_last) begin
            state      <= ST_DONE;
            sel_q      <= SEL_HOLD;
            tx_valid_q <= 1'b0;
            done       <= 1'b1;
          end
        end
        ST_DONE: begin
          state    <= ST_IDLE;
          sel_q    <= SEL_HOLD;
          done     <= 1'b0;
          busy     <= 1'b0;
          in_ready <= 1'b1;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usr_shift_sequencer.sv
// Bench for usr_shift_sequencer paired with a behavioural 4-bit USR; the stall
// scenario is compiled in when USR_SEQ_STALL_EN is defined.
module tb_usr_shift_sequencer;
  import usr_pkg::*;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_dir;
  logic             fill_bit;
`ifdef USR_SEQ_STALL_EN
  logic             tx_stall;
`endif
  logic [1:0]       usr_select;
  logic [WIDTH-1:0] usr_parallel;
  logic             usr_sright_in;
  logic             usr_sleft_in;
  logic             usr_sright_out;
  logic             usr_sleft_out;
  logic             tx_bit;
  logic             tx_valid;
  logic             done;
  logic             busy;

  usr_shift_sequencer #(.WIDTH(WIDTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .in_dir         (in_dir),
    .fill_bit       (fill_bit),
`ifdef USR_SEQ_STALL_EN
    .tx_stall       (tx_stall),
`endif
    .usr_select     (usr_select),
    .usr_parallel   (usr_parallel),
    .usr_sright_in  (usr_sright_in),
    .usr_sleft_in   (usr_sleft_in),
    .usr_sright_out (usr_sright_out),
    .usr_sleft_out  (usr_sleft_out),
    .tx_bit         (tx_bit),
    .tx_valid       (tx_valid),
    .done           (done),
    .busy           (busy)
  );

  // Behavioural universal shift register.
  logic [WIDTH-1:0] usr_q;
  always_ff @(posedge clk) begin
    if (rst) usr_q <= '0;
    else begin
      case (usr_select)
        2'd1:    usr_q <= {usr_sleft_in, usr_q[WIDTH-1:1]};
        2'd2:    usr_q <= {usr_q[WIDTH-2:0], usr_sright_in};
        2'd3:    usr_q <= usr_parallel;
        default: usr_q <= usr_q;
      endcase
    end
  end
  assign usr_sright_out = usr_q[0];
  assign usr_sleft_out  = usr_q[WIDTH-1];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every qualified bit pops the next expected bit.
  always @(negedge clk) begin
    if (tx_valid === 1'b1) begin
      if (exp_q.size() == 0) check("tx_unexpected", 32'(tx_bit), 32'h2);
      else check("tx_bit", 32'(tx_bit), 32'(exp_q.pop_front()));
    end
  end

  typedef struct {
    logic [3:0] data;
    logic       dir;
    logic       fill;
    logic [3:0] seq;      // seq[i] is the i-th emitted bit
    logic [3:0] par_end;  // USR contents at DONE
  } vec_t;

  task automatic push_seq(input logic [3:0] seq);
    for (int i = 0; i < WIDTH; i++) exp_q.push_back(seq[i]);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done !== 1'b1 && n < 20);
    check("done_seen", 32'(done), 32'h1);
  endtask

  task automatic send(input vec_t v);
    int waited = 0;
    @(negedge clk);
    in_valid = 1'b1; in_data = v.data; in_dir = v.dir; fill_bit = v.fill;
    while (in_ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("accept_ready", 32'(in_ready), 32'h1);
    push_seq(v.seq);
    @(negedge clk);
    in_valid = 1'b0; in_data = ~v.data; in_dir = ~v.dir; fill_bit = ~v.fill;
    check("load_sel", 32'(usr_select), 32'(SEL_LOAD));
    check("load_par", 32'(usr_parallel), 32'(v.data));
    check("load_sleft", 32'(usr_sleft_in), 32'(v.dir ? 1'b0 : v.fill));
    check("load_sright", 32'(usr_sright_in), 32'(v.dir ? v.fill : 1'b0));
    check("load_ready", 32'(in_ready), 32'h0);
    check("load_busy", 32'(busy), 32'h1);
    for (int i = 0; i < WIDTH; i++) begin
      @(negedge clk);
      check("shift_sel", 32'(usr_select), v.dir ? 32'h2 : 32'h1);
      check("shift_done", 32'(done), 32'h0);
    end
    @(negedge clk);
    check("done_pulse", 32'(done), 32'h1);
    check("done_sel", 32'(usr_select), 32'(SEL_HOLD));
    check("done_tx_valid", 32'(tx_valid), 32'h0);
    check("usr_end", 32'(usr_q), 32'(v.par_end));
    @(negedge clk);
    check("idle_done", 32'(done), 32'h0);
    check("idle_ready", 32'(in_ready), 32'h1);
    check("idle_busy", 32'(busy), 32'h0);
  endtask

  vec_t vecs[6];

  initial begin
    int n;
    int cnt;

    vecs[0] = '{data: 4'b1101, dir: 1'b0, fill: 1'b0, seq: 4'b1101, par_end: 4'b0000};
    vecs[1] = '{data: 4'b1101, dir: 1'b1, fill: 1'b1, seq: 4'b1011, par_end: 4'b1111};
    vecs[2] = '{data: 4'b0110, dir: 1'b1, fill: 1'b0, seq: 4'b0110, par_end: 4'b0000};
    vecs[3] = '{data: 4'b1001, dir: 1'b0, fill: 1'b1, seq: 4'b1001, par_end: 4'b1111};
    vecs[4] = '{data: 4'b0111, dir: 1'b1, fill: 1'b0, seq: 4'b1110, par_end: 4'b0000};
    vecs[5] = '{data: 4'b1000, dir: 1'b0, fill: 1'b0, seq: 4'b1000, par_end: 4'b0000};

`ifdef USR_SEQ_STALL_EN
    tx_stall = 1'b0;
`endif
    // Reset with in_valid asserted: reset must win.
    rst = 1'b1; in_valid = 1'b1; in_data = 4'b1111; in_dir = 1'b0; fill_bit = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_sel", 32'(usr_select), 32'h0);
    check("rst_par", 32'(usr_parallel), 32'h0);
    check("rst_sright", 32'(usr_sright_in), 32'h0);
    check("rst_sleft", 32'(usr_sleft_in), 32'h0);
    check("rst_tx_valid", 32'(tx_valid), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_ready", 32'(in_ready), 32'h1);
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("post_rst_busy", 32'(busy), 32'h0);
    check("post_rst_sel", 32'(usr_select), 32'h0);

    foreach (vecs[i]) send(vecs[i]);

    // Second word held valid throughout the first: only accepted once IDLE.
    @(negedge clk);
    in_valid = 1'b1; in_data = 4'b1101; in_dir = 1'b0; fill_bit = 1'b0;
    check("t4_ready_a", 32'(in_ready), 32'h1);
    push_seq(4'b1101);
    @(negedge clk);
    in_data = 4'b1100;
    check("t4_load_a", 32'(usr_parallel), 32'hd);
    cnt = 0;
    for (int i = 0; i < WIDTH + 1; i++) begin
      @(negedge clk);
      if (in_ready !== 1'b0) cnt++;
    end
    check("t4_blocked", 32'(cnt), 32'h0);
    check("t4_done_a", 32'(done), 32'h1);
    @(negedge clk);
    check("t4_idle_ready", 32'(in_ready), 32'h1);
    push_seq(4'b1100);
    @(negedge clk);
    in_valid = 1'b0;
    check("t4_load_b_sel", 32'(usr_select), 32'(SEL_LOAD));
    check("t4_load_b_par", 32'(usr_parallel), 32'hc);
    wait_done(n);
    check("t4_done_latency", 32'(n), 32'h5);
    @(negedge clk);

    // Reset during the second shift cycle discards the word without a done pulse.
    @(negedge clk);
    in_valid = 1'b1; in_data = 4'b1011; in_dir = 1'b0; fill_bit = 1'b0;
    check("t5_ready", 32'(in_ready), 32'h1);
    push_seq(4'b1011);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    check("t5_sel", 32'(usr_select), 32'h0);
    check("t5_busy", 32'(busy), 32'h0);
    check("t5_ready_after", 32'(in_ready), 32'h1);
    check("t5_tx_valid", 32'(tx_valid), 32'h0);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (done !== 1'b0) cnt++;
      @(negedge clk);
    end
    check("t5_no_done", 32'(cnt), 32'h0);
    send(vecs[0]);

`ifdef USR_SEQ_STALL_EN
    // Three stall cycles after the first bit delay done by three cycles.
    @(negedge clk);
    in_valid = 1'b1; in_data = 4'b1101; in_dir = 1'b0; fill_bit = 1'b0;
    check("t6_ready", 32'(in_ready), 32'h1);
    push_seq(4'b1101);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("t6_first_valid", 32'(tx_valid), 32'h1);
    @(posedge clk);
    #1 tx_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t6_stall_sel", 32'(usr_select), 32'h0);
      check("t6_stall_valid", 32'(tx_valid), 32'h0);
    end
    @(posedge clk);
    #1 tx_stall = 1'b0;
    wait_done(n);
    check("t6_done_delay", 32'(n), 32'h4);
    check("t6_usr_end", 32'(usr_q), 32'h0);
    @(negedge clk);
`endif

    check("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

endmodule
